// File: rtl/data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : data_mem                                                   |
// | Description : Single-port 32-bit data memory with a valid/ready request  |
// |               channel and a one-deep response channel. Byte, half and    |
// |               word loads/stores; loads sign- or zero-extend. Every       |
// |               accepted request, stores included, yields one response     |
// |               the cycle after acceptance.                                |
// | Ports       : clk, rst (sync, active-high)                               |
// |               req_valid/req_ready/req_we/req_addr/req_size/              |
// |               req_unsigned/req_wdata        - request channel            |
// |               resp_valid/resp_ready/resp_rdata/resp_err - response       |
// | Config      : DATA_MEM_ERR_EN - when defined, misaligned accesses,       |
// |               req_size=11 and out-of-range addresses raise resp_err and  |
// |               leave memory untouched; when undefined, low address bits   |
// |               are masked, size 11 acts as word and high bits alias.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module data_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_word;
    logic [31:0]      w_shift;
    logic [31:0]      w_load;
    logic             w_err;
    logic             w_hi_err;

    // Outputs are forced to their idle values for as long as rst is high,
    // not just from the edge after it, so upstream is never stalled by reset.
    assign resp_valid = (r_state == S_RESP) && !rst;
    assign resp_rdata = rst ? 32'd0 : r_rdata;
    assign resp_err   = rst ? 1'b0  : r_err;
    assign req_ready  = rst || (r_state == S_IDLE) || resp_ready;
    assign w_accept   = req_valid && req_ready && !rst;

    assign w_idx = req_addr[IDX_W+1:2];

    // Lane select / byte enables. Low address bits that do not belong to the
    // access size are masked here; in the error build such accesses are
    // flagged separately and never reach memory.
    always_comb begin
        w_lane  = req_addr[1:0];
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_lane  = {req_addr[1], 1'b0};
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_lane  = 2'b00;
            end
        endcase
    end

    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_hi
            assign w_hi_err = |req_addr[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_no_hi
            assign w_hi_err = 1'b0;
        end
    endgenerate

`ifdef DATA_MEM_ERR_EN
    assign w_err = (req_size == 2'b11)
                || ((req_size == 2'b01) && req_addr[0])
                || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                || w_hi_err;
`else
    // High address bits alias; the decode above is kept only so the port
    // width stays fully referenced.
    logic w_unused_hi;
    assign w_unused_hi = w_hi_err;
    assign w_err       = 1'b0;
`endif

    // Load path: right-align the addressed lane, then extend.
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_load = w_word;
        case (req_size)
            2'b00:   w_load = {{24{!req_unsigned && w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = {{16{!req_unsigned && w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_word;
        endcase
    end

    // Memory contents survive reset; only accepted, error-free stores write.
    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response payload is captured only on accept, so it holds steady while
    // the consumer stalls (no accept is possible then).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (req_we || w_err) ? 32'd0 : w_load;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_accept)        w_state_nxt = S_RESP;
                else if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
